mem_read_arbiter: RTL and testbench
===================================

Name: mem_read_arbiter

Overview:
- Two-master, one-slave read-channel arbiter that shares the single memory read port between the icache refill path (master 0) and the LSU/dcache read path (master 1).
- Uses the same valid/ready address and data channels as the cache-side bus, with a 3-bit response.
- Round-robin between masters; exactly one transaction outstanding at a time.
- The slave address is registered; the read-data path is routed combinationally.

Parameters:
- DATA_LEN, 32, width of the read data bus.
- ADDR_LEN, 32, width of the read address.

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-high
- m0_arvalid  input  1  icache address valid
- m0_arready  output  1  icache address ready
- m0_araddr  input  ADDR_LEN  icache read address
- m0_rvalid  output  1  icache data valid
- m0_rready  input  1  icache data ready
- m0_rresp  output  3  icache response
- m0_rdata  output  DATA_LEN  icache read data
- m1_arvalid, m1_arready, m1_araddr, m1_rvalid, m1_rready, m1_rresp, m1_rdata: same directions, widths and meanings as m0_*, for the LSU.
- s_arvalid  output  1  memory address valid
- s_arready  input  1  memory address ready
- s_araddr  output  ADDR_LEN  memory read address
- s_rvalid  input  1  memory data valid
- s_rready  output  1  memory data ready
- s_rresp  input  3  memory response
- s_rdata  input  DATA_LEN  memory read data

Behaviour:
- Interface rule: one clock, clk; reset rst is synchronous and active-high. All state updates on posedge clk.
- Reset values:
  - state=IDLE, s_arvalid=0, s_araddr=0, grant=0, last_grant=1 (so m0 wins the first tie).
  - m0/m1_arready=0 during reset; m0/m1_rvalid=0; s_rready=0.
- State machine, 3 states: IDLE, ADDR, DATA.
- IDLE, selection:
  - sel = the only requesting master if exactly one arvalid is high.
  - If both are high, sel = the master that is not last_grant.
  - mi_arready = (state==IDLE) & mi_arvalid & (sel==i). Combinational; at most one is high.
- IDLE, on mi_arvalid & mi_arready:
  - s_araddr<=mi_araddr, grant<=i, s_arvalid<=1, next state ADDR.
  - Latency: s_arvalid rises exactly 1 cycle after the master handshake.
- ADDR:
  - s_arvalid and s_araddr are held stable until s_arready.
  - On s_arvalid & s_arready: s_arvalid<=0, next state DATA.
  - Both master arready outputs are 0.
- DATA, routing:
  - m{grant}_rvalid = s_rvalid; the other master's rvalid = 0.
  - s_rready = m{grant}_rready.
  - s_rdata and s_rresp are fanned out unmodified to both m*_rdata/m*_rresp. Error responses (nonzero rresp) pass through unchanged.
- DATA, on s_rvalid & s_rready:
  - last_grant<=grant, next state IDLE.
  - The next master address handshake is possible no earlier than the following cycle.
- Outside DATA: m*_rvalid=0 and s_rready=0. A stray s_rvalid is ignored (not acknowledged).
- Only a single data beat per transaction is supported; burst lengths are not supported.
- Fairness: with both masters requesting continuously, grants strictly alternate. A requesting master waits at most one foreign transaction.
- Master address stability: a master must hold arvalid and araddr until its handshake. The arbiter samples araddr only at the handshake.
- Simultaneous events:
  - A new arvalid arriving during ADDR or DATA is stalled (arready=0) until IDLE.
  - In IDLE, both arvalid rising in the same cycle resolves per last_grant.
- Reset mid-operation:
  - Returns to the reset values on the next edge and abandons the transaction; no response is routed afterwards.
  - The memory slave shares the system reset, so no response remains in flight.
- Throughput: minimum 3 cycles per transaction (IDLE hs, ADDR hs, DATA hs) when the slave and master are zero-wait.

Test Plan:
- m0 only, araddr=0x8000_0010, slave arready=1, rdata=0x0000_0413, rresp=0 → s_arvalid high 1 cycle after the m0 handshake with s_araddr=0x8000_0010; m0_rvalid=1 with rdata=0x0000_0413; m1_rvalid stays 0.
- m0 and m1 assert arvalid together from reset (m1 addr 0xA000_0000) → m0 granted first; after m0's R handshake, m1_arready=1 next cycle and s_araddr=0xA000_0000; strictly alternating grants over 8 back-to-back requests.
- Slave delays arready 4 cycles and rvalid 5 cycles → s_arvalid and s_araddr held stable throughout; no m*_arready during the stall; a single R beat is delivered.
- Granted master holds rready=0 for 3 cycles while s_rvalid=1 → s_rready=0 for those cycles; the handshake completes on the first rready=1; the other master stays blocked.
- Slave returns rresp=3'h2 to m1 → m1_rresp=2, m1_rvalid pulse; the arbiter returns to IDLE and serves the pending m0 next.
- Assert rst for 1 cycle while in DATA with s_rvalid=1 → next cycle state IDLE, s_arvalid=0, s_rready=0, both m*_rvalid=0; first post-reset tie is granted to m0.

Source files
------------

// File: rtl/mem_read_arbiter.sv
// Two-master round-robin read arbiter sharing one memory read port.
// One transaction in flight; slave address registered, read data routed combinationally.
module mem_read_arbiter #(
  parameter int DATA_LEN = 32,
  parameter int ADDR_LEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_arvalid,
  output logic                m0_arready,
  input  logic [ADDR_LEN-1:0] m0_araddr,
  output logic                m0_rvalid,
  input  logic                m0_rready,
  output logic [2:0]          m0_rresp,
  output logic [DATA_LEN-1:0] m0_rdata,
  input  logic                m1_arvalid,
  output logic                m1_arready,
  input  logic [ADDR_LEN-1:0] m1_araddr,
  output logic                m1_rvalid,
  input  logic                m1_rready,
  output logic [2:0]          m1_rresp,
  output logic [DATA_LEN-1:0] m1_rdata,
  output logic                s_arvalid,
  input  logic                s_arready,
  output logic [ADDR_LEN-1:0] s_araddr,
  input  logic                s_rvalid,
  output logic                s_rready,
  input  logic [2:0]          s_rresp,
  input  logic [DATA_LEN-1:0] s_rdata
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t              state_reg, state_next;
  logic                s_arvalid_reg, s_arvalid_next;
  logic [ADDR_LEN-1:0] s_araddr_reg, s_araddr_next;
  logic                grant_reg, grant_next;
  logic                last_grant_reg, last_grant_next;
  logic                sel;

  // On a tie the master that did not win last time is selected.
  always_comb begin
    sel = 1'b0;
    if (m0_arvalid && m1_arvalid)
      sel = ~last_grant_reg;
    else if (m1_arvalid)
      sel = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      s_arvalid_reg  <= 1'b0;
      s_araddr_reg   <= '0;
      grant_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
    end else begin
      state_reg      <= state_next;
      s_arvalid_reg  <= s_arvalid_next;
      s_araddr_reg   <= s_araddr_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    s_arvalid_next  = s_arvalid_reg;
    s_araddr_next   = s_araddr_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    case (state_reg)
      IDLE: begin
        if (m0_arvalid && m0_arready) begin
          s_araddr_next  = m0_araddr;
          grant_next     = 1'b0;
          s_arvalid_next = 1'b1;
          state_next     = ADDR;
        end else if (m1_arvalid && m1_arready) begin
          s_araddr_next  = m1_araddr;
          grant_next     = 1'b1;
          s_arvalid_next = 1'b1;
          state_next     = ADDR;
        end
      end
      ADDR: begin
        if (s_arvalid_reg && s_arready) begin
          s_arvalid_next = 1'b0;
          state_next     = DATA;
        end
      end
      DATA: begin
        if (s_rvalid && s_rready) begin
          last_grant_next = grant_reg;
          state_next      = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs are forced low while reset is asserted.
  always_comb begin
    m0_arready = !rst && (state_reg == IDLE) && m0_arvalid && !sel;
    m1_arready = !rst && (state_reg == IDLE) && m1_arvalid && sel;
    m0_rvalid  = !rst && (state_reg == DATA) && !grant_reg && s_rvalid;
    m1_rvalid  = !rst && (state_reg == DATA) && grant_reg && s_rvalid;
    s_rready   = !rst && (state_reg == DATA) && (grant_reg ? m1_rready : m0_rready);
    s_arvalid  = s_arvalid_reg;
    s_araddr   = s_araddr_reg;
    m0_rdata   = s_rdata;
    m1_rdata   = s_rdata;
    m0_rresp   = s_rresp;
    m1_rresp   = s_rresp;
  end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Randomized bench for mem_read_arbiter against a transaction-level round-robin model.
module tb_mem_read_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready;
  logic [31:0] m0_araddr, m0_rdata;
  logic [2:0]  m0_rresp;
  logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready;
  logic [31:0] m1_araddr, m1_rdata;
  logic [2:0]  m1_rresp;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic [31:0] s_araddr, s_rdata;
  logic [2:0]  s_rresp;

  int errors = 0;
  int checks = 0;

  // Model: pending request per master, its address, and who was served last.
  logic        pend [2];
  logic [31:0] addr [2];
  int          last_g;

  always #5 clk = ~clk;

  mem_read_arbiter #(.DATA_LEN(32), .ADDR_LEN(32)) dut (
    .clk(clk), .rst(rst),
    .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rresp(m0_rresp), .m0_rdata(m0_rdata),
    .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr),
    .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rresp(m1_rresp), .m1_rdata(m1_rdata),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rresp(s_rresp), .s_rdata(s_rdata)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic get_arready(int i);
    return (i == 0) ? m0_arready : m1_arready;
  endfunction

  function automatic logic get_rvalid(int i);
    return (i == 0) ? m0_rvalid : m1_rvalid;
  endfunction

  task automatic drive_masters();
    m0_arvalid = pend[0];
    m0_araddr  = pend[0] ? addr[0] : $urandom;
    m1_arvalid = pend[1];
    m1_araddr  = pend[1] ? addr[1] : $urandom;
  endtask

  task automatic drive_rready(int win, logic v);
    if (win == 0) begin
      m0_rready = v;
      m1_rready = 1'($urandom % 2);
    end else begin
      m1_rready = v;
      m0_rready = 1'($urandom % 2);
    end
  endtask

  task automatic check_quiet_r(string tag);
    check({tag, "_s_rready"}, s_rready, 0);
    check({tag, "_rvalid"}, {m0_rvalid, m1_rvalid}, 0);
  endtask

  // One full transaction; abort asserts reset while DATA has s_rvalid pending.
  task automatic do_txn(input int d_ar, input int d_r, input int d_rr,
                        input logic [2:0] resp, input logic [31:0] data,
                        input int req_pct, input bit abort);
    int win;
    logic [31:0] exp_addr;
    if (!pend[0] && !pend[1]) begin
      win = int'($urandom % 2);
      pend[win] = 1'b1;
      addr[win] = $urandom;
    end
    win = (pend[0] && pend[1]) ? 1 - last_g : (pend[1] ? 1 : 0);
    drive_masters();
    s_arready = 1'($urandom % 2);
    s_rvalid  = 1'($urandom % 2);
    drive_rready(win, 1'($urandom % 2));
    #1;
    check("idle_arready_win", get_arready(win), 1);
    check("idle_arready_other", get_arready(1 - win), 0);
    check("idle_s_arvalid", s_arvalid, 0);
    check_quiet_r("idle");
    tick();
    pend[win] = 1'b0;
    exp_addr  = addr[win];
    for (int i = 0; i < 2; i++)
      if (!pend[i] && ($urandom % 100 < req_pct)) begin
        pend[i] = 1'b1;
        addr[i] = $urandom;
      end
    drive_masters();
    for (int k = 0; k <= d_ar; k++) begin
      s_arready = (k == d_ar);
      s_rvalid  = 1'($urandom % 2);
      drive_rready(win, 1'($urandom % 2));
      #1;
      check("addr_s_arvalid", s_arvalid, 1);
      check("addr_s_araddr", s_araddr, exp_addr);
      check("addr_arready", {m0_arready, m1_arready}, 0);
      check_quiet_r("addr");
      tick();
    end
    s_arready = 1'b0;
    if (abort) begin
      s_rvalid = 1'b1;
      s_rdata  = data;
      s_rresp  = resp;
      drive_rready(win, 1'b0);
      #1;
      check("abort_rvalid_win", get_rvalid(win), 1);
      tick();
      rst = 1'b1;
      drive_rready(win, 1'b1);
      #1;
      check("rst_arready", {m0_arready, m1_arready}, 0);
      check_quiet_r("rst");
      tick();
      rst = 1'b0;
      s_rvalid = 1'b0;
      #1;
      check("post_rst_s_arvalid", s_arvalid, 0);
      check("post_rst_s_araddr", s_araddr, 0);
      last_g = 1;
      $display("txn abort master=%0d addr=%08h", win, exp_addr);
      return;
    end
    for (int k = 0; k <= d_r + d_rr; k++) begin
      s_rvalid = (k >= d_r);
      s_rdata  = s_rvalid ? data : $urandom;
      s_rresp  = s_rvalid ? resp : 3'($urandom);
      drive_rready(win, k == d_r + d_rr);
      #1;
      check("data_rvalid_win", get_rvalid(win), s_rvalid);
      check("data_rvalid_other", get_rvalid(1 - win), 0);
      check("data_s_rready", s_rready, k == d_r + d_rr);
      check("data_rdata", {m0_rdata, m1_rdata}, {s_rdata, s_rdata});
      check("data_rresp", {m0_rresp, m1_rresp}, {s_rresp, s_rresp});
      check("data_s_arvalid", s_arvalid, 0);
      check("data_arready", {m0_arready, m1_arready}, 0);
      tick();
    end
    s_rvalid = 1'b0;
    last_g = win;
    $display("txn master=%0d addr=%08h data=%08h resp=%0d ar_wait=%0d r_wait=%0d rr_wait=%0d",
             win, exp_addr, data, resp, d_ar, d_r, d_rr);
  endtask

  initial begin
    rst = 1'b1;
    pend[0] = 1'b1; addr[0] = 32'h8000_0010;
    pend[1] = 1'b1; addr[1] = 32'hA000_0000;
    drive_masters();
    s_arready = 1'b1; s_rvalid = 1'b1; s_rdata = 32'h0; s_rresp = 3'h0;
    m0_rready = 1'b1; m1_rready = 1'b1;
    last_g = 1;
    for (int c = 0; c < 2; c++) begin
      tick();
      check("reset_arready", {m0_arready, m1_arready}, 0);
      check("reset_s_arvalid", s_arvalid, 0);
      check("reset_s_araddr", s_araddr, 0);
      check_quiet_r("reset");
    end
    rst = 1'b0;

    // m0 alone.
    pend[1] = 1'b0;
    do_txn(0, 0, 0, 3'h0, 32'h0000_0413, 0, 1'b0);
    // Tie from idle state with last grant m0 -> m1 now; then 8 back-to-back continuous.
    pend[0] = 1'b1; pend[1] = 1'b1;
    for (int n = 0; n < 8; n++)
      do_txn(0, 0, 0, 3'($urandom), $urandom, 100, 1'b0);
    // Slow slave, stalling master.
    do_txn(4, 5, 3, 3'h0, $urandom, 50, 1'b0);
    // Error response to m1 with m0 pending.
    pend[0] = 1'b0; pend[1] = 1'b1; addr[1] = 32'hA000_0040;
    do_txn(1, 1, 0, 3'h2, $urandom, 100, 1'b0);
    do_txn(0, 0, 0, 3'h0, $urandom, 0, 1'b0);
    // Random mix.
    for (int n = 0; n < 40; n++)
      do_txn(int'($urandom % 5), int'($urandom % 6), int'($urandom % 4),
             3'($urandom), $urandom, 50, 1'b0);
    // Reset during DATA, then a tie must go to m0.
    do_txn(0, 0, 0, 3'h1, $urandom, 0, 1'b1);
    pend[0] = 1'b1; addr[0] = $urandom;
    pend[1] = 1'b1; addr[1] = $urandom;
    do_txn(0, 0, 0, 3'h0, $urandom, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
